// File: rtl/text_console_engine.sv
// text_console_engine
//
// Character-buffer text console. It owns a ROWS x COLS byte array and the cursor, takes a
// ready/valid ASCII stream, interprets control codes and auto-wraps the cursor. It scrolls by
// rotating a circular top-row offset, and serves a screen-relative, one-cycle-latency read port
// to the renderer.
//
// Optional feature: define TERM_SCROLL_EN to build the scrolling path (top_row offset plus the
// StClrLine state). Without it a newline on the last row wraps the cursor back to row 0 and
// nothing is cleared.
//
// Ports
//   clk                 system clock, single domain
//   reset               synchronous, active-low; restarts a full-screen clear
//   in_valid/in_char    offered character
//   in_ready            engine accepts a character this cycle (idle only)
//   move_left..down     cursor buttons, level inputs; one step per rising edge
//   rd_col/rd_row       screen-relative read coordinate
//   rd_char             registered character at (rd_col, rd_row)
//   cursor_x/cursor_y   cursor position, screen-relative
//   busy                a clear (screen or line) is in progress
module text_console_engine #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COL_W = $clog2(COLS),
  parameter int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             move_up,
  input  logic             move_down,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_char,
  output logic [COL_W-1:0] cursor_x,
  output logic [ROW_W-1:0] cursor_y,
  output logic             busy
);

  localparam int unsigned      Cells    = ROWS * COLS;
  localparam int unsigned      AddrW    = $clog2(Cells);
  localparam logic [AddrW-1:0] ColsA    = AddrW'(COLS);
  localparam logic [AddrW-1:0] LastCell = AddrW'(Cells - 1);
  localparam logic [AddrW-1:0] LastLine = AddrW'(COLS - 1);
  localparam logic [COL_W-1:0] LastCol  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LastRow  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]   RowsW    = ROWS[ROW_W:0];
  localparam logic [7:0]       Space    = 8'h20;

`ifdef TERM_SCROLL_EN
  typedef enum logic [1:0] {StClear, StIdle, StClrLine} state_e;
`else
  typedef enum logic [1:0] {StClear, StIdle} state_e;
`endif

  // (row + top) mod ROWS; both operands are < ROWS so one conditional subtract suffices.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= RowsW) sum = sum - RowsW;
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [AddrW-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                 input logic [COL_W-1:0] col);
    return AddrW'(prow) * ColsA + AddrW'(col);
  endfunction

  state_e           state_q, state_d;
  logic [COL_W-1:0] x_q, x_d;
  logic [ROW_W-1:0] y_q, y_d;
  logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [3:0]       btn_q;
  logic [3:0]       btn;
  logic [3:0]       rise;
  logic [ROW_W-1:0] top_q;
`ifdef TERM_SCROLL_EN
  logic [ROW_W-1:0] top_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;
`else
  assign top_q = '0;
`endif

  logic             accept;
  logic             newline;
  logic             we;
  logic [AddrW-1:0] waddr;
  logic [7:0]       wdata;
  logic [AddrW-1:0] rd_addr;
  logic [7:0]       mem [Cells];

  assign btn    = {move_left, move_right, move_up, move_down};
  assign rise   = btn & ~btn_q;
  assign accept = in_valid && in_ready;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StClear;
      x_q       <= '0;
      y_q       <= '0;
      clr_cnt_q <= '0;
      btn_q     <= '0;
`ifdef TERM_SCROLL_EN
      top_q     <= '0;
      clr_row_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      clr_cnt_q <= clr_cnt_d;
      btn_q     <= btn;
`ifdef TERM_SCROLL_EN
      top_q     <= top_d;
      clr_row_q <= clr_row_d;
`endif
    end
  end

  // Next-state, cursor and write-port logic.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    clr_cnt_d = clr_cnt_q;
`ifdef TERM_SCROLL_EN
    top_d     = top_q;
    clr_row_d = clr_row_q;
`endif
    we        = 1'b0;
    waddr     = '0;
    wdata     = Space;
    newline   = 1'b0;
    unique case (state_q)
      StClear: begin
        we    = 1'b1;
        waddr = clr_cnt_q;
        if (clr_cnt_q == LastCell) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`ifdef TERM_SCROLL_EN
      StClrLine: begin
        we    = 1'b1;
        waddr = cell_addr(clr_row_q, clr_cnt_q[COL_W-1:0]);
        if (clr_cnt_q == LastLine) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`endif
      StIdle: begin
        if (accept) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            we    = 1'b1;
            waddr = cell_addr(phys_row(y_q, top_q), x_q);
            wdata = in_char;
            if (x_q == LastCol) begin
              x_d     = '0;
              newline = 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end else if (in_char == 8'h0A) begin
            x_d     = '0;
            newline = 1'b1;
          end else if (in_char == 8'h0D) begin
            x_d = '0;
          end else if (in_char == 8'h08 && x_q != '0) begin
            x_d   = x_q - 1'b1;
            we    = 1'b1;
            waddr = cell_addr(phys_row(y_q, top_q), x_q - 1'b1);
          end
          if (newline) begin
            if (y_q != LastRow) begin
              y_d = y_q + 1'b1;
            end else begin
`ifdef TERM_SCROLL_EN
              // The old top physical row becomes the new bottom row and is blanked.
              top_d     = (top_q == LastRow) ? '0 : top_q + 1'b1;
              clr_row_d = top_q;
              clr_cnt_d = '0;
              state_d   = StClrLine;
`else
              y_d = '0;
`endif
            end
          end
        end else if (rise[3]) begin
          if (x_q != '0) x_d = x_q - 1'b1;
        end else if (rise[2]) begin
          if (x_q != LastCol) x_d = x_q + 1'b1;
        end else if (rise[1]) begin
          if (y_q != '0) y_d = y_q - 1'b1;
        end else if (rise[0]) begin
          if (y_q != LastRow) y_d = y_q + 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    cursor_x = x_q;
    cursor_y = y_q;
  end

  always_ff @(posedge clk) begin
    if (reset && we) mem[waddr] <= wdata;
  end

  assign rd_addr = cell_addr(phys_row(rd_row, top_q), rd_col);

  // Read-before-write: a same-cycle write to the read cell returns the old byte.
  always_ff @(posedge clk) begin
    if (!reset) rd_char <= Space;
    else        rd_char <= mem[rd_addr];
  end

endmodule

// File: tb/tb_text_console_engine.sv
module tb_text_console_engine;

  localparam int COLS = 4;
  localparam int ROWS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready;
  logic       move_left = 1'b0, move_right = 1'b0, move_up = 1'b0, move_down = 1'b0;
  logic [1:0] rd_col = '0;
  logic [1:0] rd_row = '0;
  logic [7:0] rd_char;
  logic [1:0] cursor_x;
  logic [1:0] cursor_y;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  text_console_engine #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .move_left  (move_left),
    .move_right (move_right),
    .move_up    (move_up),
    .move_down  (move_down),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int c, input int r, output logic [7:0] v);
    rd_col = 2'(c);
    rd_row = 2'(r);
    tick();
    v = rd_char;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL wait_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    wait_ready();
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    wait_ready();
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] v;
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: ready=%0b busy=%0b, required ready=0 busy=1", in_ready, busy);
    end
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd0) begin
      errors++;
      $display("FAIL reset_cursor: (%0d,%0d), required (0,0)", cursor_x, cursor_y);
    end
    vectors++;
    if (rd_char !== 8'h20) begin
      errors++;
      $display("FAIL reset_rd_char: %h, required 20", rd_char);
    end
    reset = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      vectors++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL clear_busy: busy=%0b at cycle %0d, required 1", busy, n);
      end
      tick();
      n++;
    end
    vectors++;
    if (n !== ROWS * COLS) begin
      errors++;
      $display("FAIL clear_length: in_ready rose after %0d cycles, required %0d", n, ROWS * COLS);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: busy=%0b, required 0", busy);
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, v);
        vectors++;
        if (v !== 8'h20) begin
          errors++;
          $display("FAIL clear_cell(%0d,%0d): %h, required 20", c, r, v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rd_col   = 2'd0;
    rd_row   = 2'd0;
    in_valid = 1'b1;
    in_char  = 8'h41;
    tick();
    // Read sampled on the accepting edge sees the pre-write byte.
    vectors++;
    if (rd_char !== 8'h20) begin
      errors++;
      $display("FAIL same_cycle_read: %h, required 20", rd_char);
    end
    vectors++;
    if (cursor_x !== 2'd1 || cursor_y !== 2'd0) begin
      errors++;
      $display("FAIL b2b_cursor1: (%0d,%0d), required (1,0)", cursor_x, cursor_y);
    end
    in_char = 8'h42;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (rd_char !== 8'h41) begin
      errors++;
      $display("FAIL b2b_cell0: %h, required 41", rd_char);
    end
    rd_col = 2'd1;
    tick();
    vectors++;
    if (rd_char !== 8'h42) begin
      errors++;
      $display("FAIL b2b_cell1: %h, required 42", rd_char);
    end
    vectors++;
    if (cursor_x !== 2'd2 || cursor_y !== 2'd0) begin
      errors++;
      $display("FAIL b2b_cursor2: (%0d,%0d), required (2,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    send_char(8'h43);
    vectors++;
    if (cursor_x !== 2'd3 || cursor_y !== 2'd0) begin
      errors++;
      $display("FAIL wrap_pre: (%0d,%0d), required (3,0)", cursor_x, cursor_y);
    end
    send_char(8'h44);
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd1) begin
      errors++;
      $display("FAIL wrap_post: (%0d,%0d), required (0,1)", cursor_x, cursor_y);
    end
    read_cell(3, 0, v);
    vectors++;
    if (v !== 8'h44) begin
      errors++;
      $display("FAIL wrap_cell: %h, required 44", v);
    end
  endtask

  task automatic test_backspace();
    logic [7:0] v;
    send_char(8'h08);
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd1) begin
      errors++;
      $display("FAIL bs_at_zero: (%0d,%0d), required (0,1)", cursor_x, cursor_y);
    end
    send_char(8'h78);
    send_char(8'h79);
    send_char(8'h08);
    vectors++;
    if (cursor_x !== 2'd1 || cursor_y !== 2'd1) begin
      errors++;
      $display("FAIL bs_cursor: (%0d,%0d), required (1,1)", cursor_x, cursor_y);
    end
    read_cell(1, 1, v);
    vectors++;
    if (v !== 8'h20) begin
      errors++;
      $display("FAIL bs_cell: %h, required 20", v);
    end
    read_cell(0, 1, v);
    vectors++;
    if (v !== 8'h78) begin
      errors++;
      $display("FAIL bs_keep: %h, required 78", v);
    end
    send_char(8'h0D);
    send_char(8'h01);
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cr_other: (%0d,%0d) ready=%0b, required (0,1) ready=1",
               cursor_x, cursor_y, in_ready);
    end
  endtask

  task automatic test_moves();
    // Cursor starts at (0,1).
    move_left = 1'b1;
    repeat (3) tick();
    move_left = 1'b0;
    tick();
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd1) begin
      errors++;
      $display("FAIL left_clamp: (%0d,%0d), required (0,1)", cursor_x, cursor_y);
    end
    move_right = 1'b1;
    repeat (5) tick();
    move_right = 1'b0;
    tick();
    vectors++;
    if (cursor_x !== 2'd1 || cursor_y !== 2'd1) begin
      errors++;
      $display("FAIL right_hold: (%0d,%0d), required (1,1)", cursor_x, cursor_y);
    end
    move_down = 1'b1; tick(); move_down = 1'b0; tick();
    move_down = 1'b1; tick(); move_down = 1'b0; tick();
    vectors++;
    if (cursor_x !== 2'd1 || cursor_y !== 2'd2) begin
      errors++;
      $display("FAIL down_clamp: (%0d,%0d), required (1,2)", cursor_x, cursor_y);
    end
    move_up = 1'b1; tick(); move_up = 1'b0; tick();
    vectors++;
    if (cursor_x !== 2'd1 || cursor_y !== 2'd1) begin
      errors++;
      $display("FAIL up_step: (%0d,%0d), required (1,1)", cursor_x, cursor_y);
    end
    move_left = 1'b1; move_right = 1'b1; tick();
    move_left = 1'b0; move_right = 1'b0; tick();
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd1) begin
      errors++;
      $display("FAIL prio_lr: (%0d,%0d), required (0,1)", cursor_x, cursor_y);
    end
    move_up = 1'b1; move_down = 1'b1; tick();
    move_up = 1'b0; move_down = 1'b0; tick();
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd0) begin
      errors++;
      $display("FAIL prio_ud: (%0d,%0d), required (0,0)", cursor_x, cursor_y);
    end
    in_valid = 1'b1; in_char = 8'h7A; move_right = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    move_right = 1'b0;
    tick();
    vectors++;
    if (cursor_x !== 2'd1 || cursor_y !== 2'd0) begin
      errors++;
      $display("FAIL move_dropped: (%0d,%0d), required (1,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_scroll();
    logic [7:0] v;
    logic [7:0] exp_rows [3][4];
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) send_char(8'h61);
    for (int i = 0; i < 4; i++) send_char(8'h62);
    for (int i = 0; i < 3; i++) send_char(8'h63);
    vectors++;
    if (cursor_x !== 2'd3 || cursor_y !== 2'd2) begin
      errors++;
      $display("FAIL fill_cursor: (%0d,%0d), required (3,2)", cursor_x, cursor_y);
    end
    send_char(8'h0A);
`ifdef TERM_SCROLL_EN
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL scroll_cursor: (%0d,%0d) busy=%0b, required (0,2) busy=1",
               cursor_x, cursor_y, busy);
    end
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== COLS) begin
      errors++;
      $display("FAIL scroll_stall: in_ready low %0d cycles, required %0d", n, COLS);
    end
    exp_rows[0] = '{8'h62, 8'h62, 8'h62, 8'h62};
    exp_rows[1] = '{8'h63, 8'h63, 8'h63, 8'h20};
    exp_rows[2] = '{8'h20, 8'h20, 8'h20, 8'h20};
`else
    n = 0;
    vectors++;
    if (cursor_x !== 2'd0 || cursor_y !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_row_cursor: (%0d,%0d) ready=%0b, required (0,0) ready=1",
               cursor_x, cursor_y, in_ready);
    end
    exp_rows[0] = '{8'h61, 8'h61, 8'h61, 8'h61};
    exp_rows[1] = '{8'h62, 8'h62, 8'h62, 8'h62};
    exp_rows[2] = '{8'h63, 8'h63, 8'h63, 8'h20};
`endif
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, v);
        vectors++;
        if (v !== exp_rows[r][c]) begin
          errors++;
          $display("FAIL screen(%0d,%0d): %h, required %h", c, r, v, exp_rows[r][c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_backspace();
    test_moves();
    test_scroll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
